// File: rtl/reg_native_if_pkg.sv
// Shared types for reg_native_if adapters: FSM states, request record,
// counter sizing and request legality.
package reg_native_if_pkg;

  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [REQ_DATA_W-1:0] wr_data;
  } req_t;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Exactly one direction, and no address bits above the downstream bus width.
  function automatic logic req_legal(input req_t req, input int down_addr_w);
    return (req.wr_en ^ req.rd_en) && ((req.addr >> down_addr_w) == '0);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expired flags the enabled cycle that
// reaches LIMIT. LIMIT of 0 disables expiry.
module apb_timeout_cnt
  import reg_native_if_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (LIMIT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/reg_native_if2apb.sv
// Bridges single-outstanding reg_native_if requests onto an APB3 master
// port, with one ack per accepted request and a bounded slave wait.
module reg_native_if2apb
  import reg_native_if_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_RD_DATA = 32'hDEAD_BEEF
) (
  input  logic                      native_clk,
  input  logic                      native_rst_n,
  input  logic                      req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  output logic                      ack_vld,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      ack_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [BUS_DATA_WIDTH-1:0] pwdata,
  input  logic [BUS_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic                      overrun,
  output state_e                    fsm_state
);

  // Handshake: req_vld is a one-cycle pulse honoured only in IDLE; every
  // honoured request yields exactly one ack_vld pulse, and rd_data/ack_err
  // are meaningful only while ack_vld is high. req_vld outside IDLE is
  // dropped and latches overrun.

  state_e state;
  req_t   req_in;
  logic   legal;
  logic   cnt_clear;
  logic   cnt_enable;
  logic   expired;

  always_comb begin
    req_in         = '0;
    req_in.addr    = REQ_ADDR_W'(addr);
    req_in.wr_en   = wr_en;
    req_in.rd_en   = rd_en;
    req_in.wr_data = REQ_DATA_W'(wr_data);
  end

  assign legal      = req_legal(req_in, APB_ADDR_WIDTH);
  assign cnt_clear  = (state == IDLE) && req_vld && legal;
  assign cnt_enable = (state == ACCESS) && !pready;
  assign fsm_state  = state;

  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (native_clk),
    .rst_n  (native_rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n) begin
      state   <= IDLE;
      ack_vld <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      overrun <= 1'b0;
    end else begin
      if (req_vld && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req_vld) begin
            if (legal) begin
              state   <= SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= req_in.wr_en;
              paddr   <= req_in.addr[APB_ADDR_WIDTH-1:0];
              pwdata  <= req_in.wr_en ? BUS_DATA_WIDTH'(req_in.wr_data) : '0;
            end else begin
              state   <= RESP;
              ack_vld <= 1'b1;
              ack_err <= 1'b1;
              rd_data <= ERR_RD_DATA;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            ack_err <= pslverr;
            if (pslverr) begin
              rd_data <= ERR_RD_DATA;
            end else if (pwrite) begin
              rd_data <= '0;
            end else begin
              rd_data <= prdata;
            end
          end else if (expired) begin
            // Hung slave: abandon the transfer rather than stall dispatch.
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            ack_err <= 1'b1;
            rd_data <= ERR_RD_DATA;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_vld <= 1'b0;
          ack_err <= 1'b0;
          rd_data <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_if2apb.sv
// Directed bench for reg_native_if2apb: scoreboard of expected acks,
// an APB slave responder and a monitor popping on every ack_vld.
module tb_reg_native_if2apb;
  import reg_native_if_pkg::*;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int PW = 32;
  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int HANG = 1000;

  logic          clk;
  logic          native_rst_n;
  logic          req_vld;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wr_data;
  logic          ack_vld;
  logic [DW-1:0] rd_data;
  logic          ack_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [PW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready = 1'b0;
  logic          pslverr;
  logic          overrun;
  state_e        fsm_state;

  // {expected ack cycle, ack_err, rd_data}
  logic [64:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          cfg_waits = 0;
  logic [31:0] cfg_paddr = '0;
  int          wcnt = 0;

  reg_native_if2apb #(
    .BUS_DATA_WIDTH(DW),
    .BUS_ADDR_WIDTH(AW),
    .APB_ADDR_WIDTH(PW),
    .TIMEOUT_CYCLES(TO),
    .ERR_RD_DATA   (ERR)
  ) dut (
    .native_clk  (clk),
    .native_rst_n(native_rst_n),
    .req_vld     (req_vld),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_data     (wr_data),
    .ack_vld     (ack_vld),
    .rd_data     (rd_data),
    .ack_err     (ack_err),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .overrun     (overrun),
    .fsm_state   (fsm_state)
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave: pready after cfg_waits wait states; checks paddr holds in ACCESS
  always @(negedge clk) begin
    if (psel && penable) begin
      chk("paddr_stable", 65'(paddr), 65'(cfg_paddr));
      if (wcnt >= cfg_waits) begin
        pready = 1'b1;
      end else begin
        pready = 1'b0;
        wcnt++;
      end
    end else begin
      pready = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: every ack must match the head of the expected queue
  always @(negedge clk) begin
    if (native_rst_n && ack_vld) begin
      chk("apb_idle_at_ack", 65'({psel, penable}), 65'(0));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack_vld=1 err=%0b data=%08h, required no ack", ack_err, rd_data);
      end else begin
        chk("ack_cycle_err_data", {32'(cyc), ack_err, rd_data}, exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got %0d acks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [63:0] a, input logic w, input logic r,
                       input logic [31:0] wd, input int waits,
                       input logic [31:0] rdv, input logic serr,
                       input logic exp_err, input logic [31:0] exp_data,
                       input int lat);
    logic legal;
    logic [31:0] due;
    legal = (lat != 1);
    @(negedge clk);
    cfg_waits = waits;
    cfg_paddr = a[31:0];
    prdata    = rdv;
    pslverr   = serr;
    addr      = a;
    wr_en     = w;
    rd_en     = r;
    wr_data   = wd;
    req_vld   = 1'b1;
    due       = 32'(cyc + lat);
    exp_q.push_back({due, exp_err, exp_data});
    @(negedge clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    chk("setup_psel_penable", 65'({psel, penable}), legal ? 65'(2) : 65'(0));
    if (legal) begin
      chk("setup_paddr", 65'(paddr), 65'(a[31:0]));
      chk("setup_pwrite", 65'(pwrite), 65'(w));
      chk("setup_pwdata", 65'(pwdata), w ? 65'(wd) : 65'(0));
    end
    @(negedge clk);
    chk("access_psel_penable", 65'({psel, penable}), legal ? 65'(3) : 65'(0));
    drain();
  endtask

  initial begin
    logic [31:0] due;
    native_rst_n = 1'b0;
    req_vld = 1'b0;
    addr    = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    prdata  = '0;
    pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack_vld", 65'(ack_vld), 65'(0));
    chk("rst_ack_err", 65'(ack_err), 65'(0));
    chk("rst_rd_data", 65'(rd_data), 65'(0));
    chk("rst_psel_penable_pwrite", 65'({psel, penable, pwrite}), 65'(0));
    chk("rst_paddr", 65'(paddr), 65'(0));
    chk("rst_pwdata", 65'(pwdata), 65'(0));
    chk("rst_overrun", 65'(overrun), 65'(0));
    chk("rst_state", 65'(fsm_state), 65'(IDLE));
    native_rst_n = 1'b1;
    @(negedge clk);

    //     addr                   wr    rd    wr_data        waits prdata         slverr err   rd_data        lat
    issue(64'h10,                 1'b1, 1'b0, 32'hA5A5_0001, 0,    32'h0,         1'b0,  1'b0, 32'h0,         3);
    issue(64'h20,                 1'b0, 1'b1, 32'h0,         2,    32'h1234_5678, 1'b0,  1'b0, 32'h1234_5678, 5);
    issue(64'h30,                 1'b0, 1'b1, 32'h0,         1,    32'h5555_5555, 1'b1,  1'b1, ERR,           4);
    issue(64'h40,                 1'b0, 1'b1, 32'h0,         HANG, 32'h7777_7777, 1'b0,  1'b1, ERR,           6);
    chk("state_after_timeout", 65'(fsm_state), 65'(IDLE));
    issue(64'h44,                 1'b0, 1'b1, 32'h0,         0,    32'hCAFE_0001, 1'b0,  1'b0, 32'hCAFE_0001, 3);
    issue(64'h10,                 1'b1, 1'b1, 32'h1111_2222, 0,    32'h0,         1'b0,  1'b1, ERR,           1);
    issue(64'h1_0000_0000,        1'b0, 1'b1, 32'h0,         0,    32'h0,         1'b0,  1'b1, ERR,           1);
    issue(64'h10,                 1'b0, 1'b0, 32'h0,         0,    32'h0,         1'b0,  1'b1, ERR,           1);
    issue(64'h14,                 1'b1, 1'b0, 32'h3333_4444, 0,    32'h0,         1'b1,  1'b1, ERR,           3);
    issue(64'hFFFF_FFFC,          1'b0, 1'b1, 32'h0,         0,    32'h8765_4321, 1'b0,  1'b0, 32'h8765_4321, 3);
    issue(64'h18,                 1'b1, 1'b0, 32'h0BAD_CAFE, 3,    32'hFFFF_FFFF, 1'b0,  1'b0, 32'h0,         6);
    chk("overrun_clear_before", 65'(overrun), 65'(0));

    // Second request during ACCESS is dropped; only the first is acked
    @(negedge clk);
    cfg_waits = 3;
    cfg_paddr = 32'h50;
    prdata    = 32'h0BAD_F00D;
    pslverr   = 1'b0;
    addr      = 64'h50;
    rd_en     = 1'b1;
    req_vld   = 1'b1;
    due       = 32'(cyc + 6);
    exp_q.push_back({due, 1'b0, 32'h0BAD_F00D});
    @(negedge clk);
    req_vld = 1'b0;
    rd_en   = 1'b0;
    @(negedge clk);
    addr    = 64'h99;
    wr_en   = 1'b1;
    req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 65'(overrun), 65'(1));

    // Reset in ACCESS: APB drops at once, no ack, overrun cleared
    @(negedge clk);
    cfg_waits = HANG;
    cfg_paddr = 32'h60;
    addr      = 64'h60;
    rd_en     = 1'b1;
    req_vld   = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    rd_en   = 1'b0;
    @(negedge clk);
    chk("pre_reset_access", 65'({psel, penable}), 65'(3));
    #2 native_rst_n = 1'b0;
    #1;
    chk("mid_reset_apb", 65'({psel, penable}), 65'(0));
    chk("mid_reset_overrun", 65'(overrun), 65'(0));
    chk("mid_reset_ack", 65'(ack_vld), 65'(0));
    repeat (2) @(negedge clk);
    native_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_state", 65'(fsm_state), 65'(IDLE));
    issue(64'h64,                 1'b0, 1'b1, 32'h0,         1,    32'h2468_ACE0, 1'b0,  1'b0, 32'h2468_ACE0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
